// File: rtl/axi_lite_master_pkg.sv
// Shared definitions for the AXI4-Lite single-outstanding master.
package axi_lite_master_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 32;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns one user command into one AXI-Lite read or write
// and reports a single completion. Only one transaction is ever in flight.
// Every AXI VALID and READY is a flop or a decode of the state register, so
// nothing here depends combinationally on a slave READY/VALID input.
module axi_lite_master
    import axi_lite_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // user command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    // user completion
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    // write address / data
    output logic [ADDR_W-1:0]     AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    // write response
    input  logic                  BVALID,
    output logic                  BREADY,
    // read address / data
    output logic [ADDR_W-1:0]     ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [STRB_W-1:0]   wstrb_q,     wstrb_d;
    logic                awvalid_q,   awvalid_d;
    logic                wvalid_q,    wvalid_d;
    logic                arvalid_q,   arvalid_d;
    logic                rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    // Next-state and datapath update for the transaction sequencer
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently; leave only when both have
                if (awvalid_q && AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (BVALID) begin
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = DONE;
                end
            end
            RD_REQ: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RVALID) begin
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = RDATA;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // cmd_ready is masked by reset so nothing is accepted while it is held
    assign cmd_ready = (state_q == IDLE) && ARESETn;
    assign rsp_valid = (state_q == DONE);
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign BREADY    = (state_q == WR_RESP);
    assign RREADY    = (state_q == RD_DATA);
    assign AWADDR    = addr_q;
    assign ARADDR    = addr_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign AWVALID   = awvalid_q;
    assign WVALID    = wvalid_q;
    assign ARVALID   = arvalid_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a table of single transactions with a
// cycle-scripted slave, plus hand-written reset-abort and back-to-back cases.
module tb_axi_lite_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [3:0]  AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_master #(.ADDR_W(4), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
    );

    // Slave timing is given as the first cycle (counted from the command
    // accept cycle 0) at which each READY / response VALID is offered.
    // Expected handshake cycles are 0 when no handshake should occur.
    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_c, w_c, ar_c, b_c, r_c;
        logic [31:0] rdata;
        int          hold;
        int          e_aw, e_w, e_ar, e_resp, e_rsp;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(logic wr, logic [3:0] addr, logic [31:0] wdata,
                                logic [3:0] wstrb, int aw_c, int w_c, int ar_c,
                                int b_c, int r_c, logic [31:0] rdata, int hold,
                                int e_aw, int e_w, int e_ar, int e_resp,
                                int e_rsp, logic [31:0] e_rdata);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.aw_c = aw_c; v.w_c = w_c; v.ar_c = ar_c; v.b_c = b_c; v.r_c = r_c;
        v.rdata = rdata; v.hold = hold;
        v.e_aw = e_aw; v.e_w = e_w; v.e_ar = e_ar; v.e_resp = e_resp;
        v.e_rsp = e_rsp; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_slave();
        AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
        BVALID = 1'b0; RVALID = 1'b0; RDATA = 32'h0;
    endtask

    // Runs one transaction; entered and left just after a falling edge.
    task automatic run_vec(input vec_t v, input string tag);
        int   aw_cyc = 0, w_cyc = 0, ar_cyc = 0, resp_cyc = 0, rsp_cyc = 0;
        int   awv_cnt = 0, wv_cnt = 0, arv_cnt = 0, perr = 0;
        logic b_seen = 1'b0, r_seen = 1'b0, fin = 1'b0;
        logic        s_wr;
        logic [31:0] s_rd;
        s_wr = 1'bx;
        s_rd = 32'hx;
        cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        cmd_wstrb = v.wstrb; cmd_valid = 1'b1; rsp_ready = 1'b0;
        AWREADY = (0 >= v.aw_c); WREADY = (0 >= v.w_c); ARREADY = (0 >= v.ar_c);
        BVALID = (0 >= v.b_c); RVALID = (0 >= v.r_c);
        RDATA = RVALID ? v.rdata : 32'h0;
        chk({tag, " cmd_ready at accept"}, cmd_ready, 1);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            AWREADY = (t >= v.aw_c);
            WREADY  = (t >= v.w_c);
            ARREADY = (t >= v.ar_c);
            BVALID  = (t >= v.b_c) && !b_seen;
            RVALID  = (t >= v.r_c) && !r_seen;
            RDATA   = RVALID ? v.rdata : 32'h0;
            if (cmd_ready) perr++;
            if (AWVALID) begin awv_cnt++; if (AWADDR !== v.addr) perr++; end
            if (WVALID) begin
                wv_cnt++;
                if (WDATA !== v.wdata || WSTRB !== v.wstrb) perr++;
            end
            if (ARVALID) begin arv_cnt++; if (ARADDR !== v.addr) perr++; end
            if (BREADY && (!v.wr || aw_cyc == 0 || w_cyc == 0)) perr++;
            if (RREADY && (v.wr || ar_cyc == 0)) perr++;
            if (AWVALID && AWREADY) aw_cyc = t;
            if (WVALID && WREADY)   w_cyc = t;
            if (ARVALID && ARREADY) ar_cyc = t;
            if (BVALID && BREADY) begin b_seen = 1'b1; resp_cyc = t; end
            if (RVALID && RREADY) begin r_seen = 1'b1; resp_cyc = t; end
            if (rsp_valid) begin
                if (rsp_cyc == 0) begin
                    rsp_cyc = t; s_wr = rsp_write; s_rd = rsp_rdata;
                end else if (rsp_write !== s_wr || rsp_rdata !== s_rd) perr++;
                if (t - rsp_cyc >= v.hold) begin rsp_ready = 1'b1; fin = 1'b1; end
            end
            @(negedge ACLK);
            if (fin) break;
        end
        rsp_ready = 1'b0;
        idle_slave();
        chk({tag, " AW handshake cycle"}, aw_cyc, v.e_aw);
        chk({tag, " W handshake cycle"}, w_cyc, v.e_w);
        chk({tag, " AR handshake cycle"}, ar_cyc, v.e_ar);
        chk({tag, " B/R handshake cycle"}, resp_cyc, v.e_resp);
        chk({tag, " rsp_valid cycle"}, rsp_cyc, v.e_rsp);
        chk({tag, " rsp_write"}, s_wr, v.wr);
        chk({tag, " rsp_rdata"}, s_rd, v.e_rdata);
        chk({tag, " AWVALID high cycles"}, awv_cnt, v.e_aw);
        chk({tag, " WVALID high cycles"}, wv_cnt, v.e_w);
        chk({tag, " ARVALID high cycles"}, arv_cnt, v.e_ar);
        chk({tag, " protocol/stability errors"}, perr, 0);
        chk({tag, " idle after rsp"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t rcv;
        logic seen, rv;
        int   rsp1, acc2, rsp2;
        logic        r2_wr;
        logic [31:0] r2_rd;

        //              wr addr   wdata          strb aw w  ar b  r  rdata          hold eaw ew ear ers ersp erdata
        vecs[0] = mk(1, 4'h4, 32'hA5A5_1234, 4'hF, 0, 0, 99, 0, 99, 32'h0,          0, 1, 1, 0, 2, 3, 32'h0);
        vecs[1] = mk(1, 4'h4, 32'h0F0F_0F0F, 4'hF, 1, 4, 99, 0, 99, 32'h0,          0, 1, 4, 0, 5, 6, 32'h0);
        vecs[2] = mk(0, 4'h8, 32'h0,         4'h0, 99,99, 0, 99, 4, 32'hDEAD_BEEF,  0, 0, 0, 1, 4, 5, 32'hDEAD_BEEF);
        vecs[3] = mk(1, 4'hC, 32'h0000_00FF, 4'h1, 3, 0, 99, 0, 99, 32'h0,          0, 3, 1, 0, 4, 5, 32'h0);
        vecs[4] = mk(0, 4'h2, 32'h0,         4'h0, 99,99, 2, 99, 0, 32'h0BAD_F00D,  5, 0, 0, 2, 3, 4, 32'h0BAD_F00D);
        vecs[5] = mk(1, 4'h6, 32'h1111_2222, 4'hA, 2, 2, 99, 5, 99, 32'h0,          5, 2, 2, 0, 5, 6, 32'h0);
        rcv     = mk(0, 4'h8, 32'h0,         4'h0, 99,99, 0, 99, 0, 32'hCAFE_0001,  0, 0, 0, 1, 2, 3, 32'hCAFE_0001);

        ARESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
        idle_slave();

        // reset state
        @(negedge ACLK);
        chk("reset: control outputs",
            {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, cmd_ready}, 7'b0);
        chk("reset: addr/data outputs", {AWADDR, ARADDR, WDATA, WSTRB}, 44'h0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        chk("reset: cmd_ready after release", cmd_ready, 1);
        @(negedge ACLK);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // reset while waiting in WR_RESP
        cmd_write = 1'b1; cmd_addr = 4'hA; cmd_wdata = 32'h55AA_55AA; cmd_wstrb = 4'hF;
        AWREADY = 1'b1; WREADY = 1'b1; cmd_valid = 1'b1;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (BREADY) seen = 1'b1;
            else @(negedge ACLK);
        end
        chk("rstmid: reached WR_RESP", seen, 1);
        ARESETn = 1'b0;
        BVALID = 1'b1;
        #1;
        chk("rstmid: control outputs",
            {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, cmd_ready}, 7'b0);
        chk("rstmid: addr/data outputs", {AWADDR, WDATA, WSTRB}, 40'h0);
        rv = 1'b0;
        repeat (2) begin @(negedge ACLK); rv = rv | rsp_valid; end
        ARESETn = 1'b1;
        #1;
        chk("rstmid: cmd_ready after release", cmd_ready, 1);
        @(negedge ACLK);
        rv = rv | rsp_valid | BREADY;
        chk("rstmid: no completion reported", rv, 0);
        idle_slave();
        run_vec(rcv, "rstmid read");

        // back-to-back write then read with cmd_valid held
        AWREADY = 1'b1; WREADY = 1'b1; ARREADY = 1'b1;
        BVALID = 1'b1; RVALID = 1'b1; RDATA = 32'h1357_9BDF; rsp_ready = 1'b1;
        cmd_write = 1'b1; cmd_addr = 4'h1; cmd_wdata = 32'h0000_0042; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        chk("b2b: cmd_ready at first accept", cmd_ready, 1);
        rsp1 = 0; acc2 = 0; rsp2 = 0;
        r2_wr = 1'bx; r2_rd = 32'hx;
        @(negedge ACLK);
        for (int t = 1; t <= 20 && rsp2 == 0; t++) begin
            if (cmd_ready && acc2 == 0) acc2 = t;
            else if (acc2 != 0) cmd_valid = 1'b0;
            if (rsp_valid) begin
                if (rsp1 == 0) begin
                    rsp1 = t;
                    chk("b2b: first rsp_write", rsp_write, 1);
                    cmd_write = 1'b0; cmd_addr = 4'h3;
                end else if (acc2 != 0) begin
                    rsp2 = t; r2_wr = rsp_write; r2_rd = rsp_rdata;
                end
            end
            @(negedge ACLK);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        idle_slave();
        chk("b2b: first rsp cycle", rsp1, 3);
        chk("b2b: second accept cycle", acc2, 4);
        chk("b2b: second rsp cycle", rsp2, 7);
        chk("b2b: second rsp_write", r2_wr, 0);
        chk("b2b: second rsp_rdata", r2_rd, 32'h1357_9BDF);
        @(negedge ACLK);
        chk("b2b: idle at end", {rsp_valid, cmd_ready}, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
